corescore_mmcm_drp_ctrl: RTL and testbench

Sequencer for the MMCME4 that clocks the CoreScore array. It runs on the free-running board reference clock and drives the MMCM reset and DRP port. At power-up it holds the MMCM in reset, then waits for lock; afterwards it performs run-time read-modify-write reprogramming of the CLKOUT0 divider. It also produces the core-domain reset request that gates the SERV array while the generated clock is invalid.

---
 rtl/corescore_mmcm_drp_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_corescore_mmcm_drp_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_mmcm_drp_ctrl.sv
// corescore_mmcm_drp_ctrl
//
// Reset and DRP sequencer for the MMCME4 that clocks the CoreScore array.
// Runs on the free-running reference clock. After reset it pulses the MMCM
// reset, waits for a stable lock and releases the core reset. On request it
// holds the MMCM in reset, read-modify-writes the CLKOUT0 divider registers
// (ClkReg1, then ClkReg2) over DRP, releases the MMCM and waits for lock again.
//
// Ports
//   i_clk       reference / DRP clock
//   i_rst_n     synchronous active-low reset
//   i_req       reconfigure request, level, sampled only in IDLE
//   i_div       new CLKOUT0 divide value (0 is treated as 1), captured with i_req
//   o_busy      sequencer not in IDLE
//   o_done      one-cycle pulse when lock is reached and core reset drops
//   o_err       sticky DRDY / lock timeout flag, cleared by next accepted i_req
//   o_daddr     DRP address
//   o_di        DRP write data
//   i_do        DRP read data
//   o_den       DRP enable, one cycle per access
//   o_dwe       DRP write enable, only together with o_den
//   i_drdy      DRP ready
//   o_mmcm_rst  MMCM RST
//   i_locked    MMCM LOCKED, asynchronous
//   o_rst       core reset request, active high
//
// Build option
//   CORESCORE_LOCK_MON_EN  when defined, loss of lock while IDLE re-raises
//                          o_rst and waits for lock again (no DRP access,
//                          no MMCM reset). When undefined, lk is ignored in IDLE.

module corescore_mmcm_drp_ctrl #(
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 1_000_000,
    parameter logic [6:0]  REG1_ADDR    = 7'h08,
    parameter logic [6:0]  REG2_ADDR    = 7'h09
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [7:0]  i_div,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [6:0]  o_daddr,
    output logic [15:0] o_di,
    input  logic [15:0] i_do,
    output logic        o_den,
    output logic        o_dwe,
    input  logic        i_drdy,
    output logic        o_mmcm_rst,
    input  logic        i_locked,
    output logic        o_rst
);

    typedef enum logic [3:0] {
        S_PRST,
        S_PWAIT,
        S_LOCKWAIT,
        S_IDLE,
        S_MRST,
        S_RD,
        S_RWAIT,
        S_WR,
        S_WWAIT,
        S_RELEASE
    } state_t;

    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] TMO_LAST  = 32'(LOCK_TIMEOUT - 1);

    // Bits of the read word that survive the merge.
    localparam logic [15:0] REG1_KEEP = 16'hF000;
    localparam logic [15:0] REG2_KEEP = 16'hF3FF;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        lk_meta_q, lk_q;
    logic        lk_seen_q, lk_seen_d;
    logic        idx_q, idx_d;
    logic [7:0]  div_q, div_d;

    logic        mmcm_rst_q, mmcm_rst_d;
    logic        rst_q, rst_d;
    logic        busy_q, busy_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

`ifdef CORESCORE_LOCK_MON_EN
    logic        lk_prev_q;
`endif

    // Builds the write word for register idx (0 = ClkReg1, 1 = ClkReg2)
    // from the divider d (already forced to >= 1) and the read-back word.
    function automatic logic [15:0] merge_word(input logic        idx,
                                               input logic [7:0]  d,
                                               input logic [15:0] rd);
        logic [5:0] hi;
        logic [5:0] lo;
        if (d > 8'd63) begin
            hi = '1;
            lo = '1;
        end else begin
            // For d <= 63 both halves fit in six bits.
            hi = d[6:1];
            lo = d[5:0] - d[6:1];
        end
        if (!idx) begin
            merge_word = (rd & REG1_KEEP) | {4'b0000, hi, lo};
        end else begin
            merge_word = (rd & REG2_KEEP) | {4'b0000, d[0], (d == 8'd1), 10'b0};
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lk_seen_d  = 1'b0;
        idx_d      = idx_q;
        div_d      = div_q;
        mmcm_rst_d = mmcm_rst_q;
        rst_d      = rst_q;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        daddr_d    = daddr_q;
        di_d       = di_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_PRST: begin
                mmcm_rst_d = 1'b1;
                rst_d      = 1'b1;
                cnt_d      = cnt_q + 32'd1;
                if (cnt_q == HOLD_LAST) begin
                    state_d    = S_PWAIT;
                    mmcm_rst_d = 1'b0;
                end
            end

            S_PWAIT: begin
                state_d = S_LOCKWAIT;
                cnt_d   = '0;
            end

            S_LOCKWAIT: begin
                // lk_seen_q remembers lk from the previous LOCKWAIT cycle,
                // so two consecutive high samples are needed.
                lk_seen_d = lk_q;
                cnt_d     = cnt_q + 32'd1;
                if (lk_q && lk_seen_q) begin
                    state_d = S_IDLE;
                    rst_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = S_PRST;
                    err_d      = 1'b1;
                    mmcm_rst_d = 1'b1;
                    cnt_d      = '0;
                end
            end

            S_IDLE: begin
`ifdef CORESCORE_LOCK_MON_EN
                if (lk_prev_q && !lk_q) begin
                    state_d = S_LOCKWAIT;
                    rst_d   = 1'b1;
                    cnt_d   = '0;
                end else
`endif
                if (i_req) begin
                    state_d    = S_MRST;
                    div_d      = (i_div == 8'd0) ? 8'd1 : i_div;
                    idx_d      = 1'b0;
                    err_d      = 1'b0;
                    rst_d      = 1'b1;
                    mmcm_rst_d = 1'b1;
                end
            end

            S_MRST: begin
                state_d = S_RD;
                den_d   = 1'b1;
                daddr_d = REG1_ADDR;
            end

            S_RD: begin
                // DRDY in the enable cycle itself is not accepted.
                state_d = S_RWAIT;
                cnt_d   = '0;
            end

            S_RWAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (i_drdy) begin
                    state_d = S_WR;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    di_d    = merge_word(idx_q, div_q, i_do);
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = S_RELEASE;
                    err_d      = 1'b1;
                    mmcm_rst_d = 1'b0;
                end
            end

            S_WR: begin
                state_d = S_WWAIT;
                cnt_d   = '0;
            end

            S_WWAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (i_drdy) begin
                    if (!idx_q) begin
                        state_d = S_RD;
                        idx_d   = 1'b1;
                        den_d   = 1'b1;
                        daddr_d = REG2_ADDR;
                    end else begin
                        state_d    = S_RELEASE;
                        mmcm_rst_d = 1'b0;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = S_RELEASE;
                    err_d      = 1'b1;
                    mmcm_rst_d = 1'b0;
                end
            end

            S_RELEASE: begin
                state_d = S_LOCKWAIT;
                cnt_d   = '0;
            end

            default: begin
                state_d    = S_PRST;
                mmcm_rst_d = 1'b1;
                rst_d      = 1'b1;
                cnt_d      = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lk_meta_q  <= 1'b0;
            lk_q       <= 1'b0;
            state_q    <= S_PRST;
            cnt_q      <= '0;
            lk_seen_q  <= 1'b0;
            idx_q      <= 1'b0;
            div_q      <= 8'd1;
            mmcm_rst_q <= 1'b1;
            rst_q      <= 1'b1;
            busy_q     <= 1'b1;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            lk_meta_q  <= i_locked;
            lk_q       <= lk_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lk_seen_q  <= lk_seen_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            mmcm_rst_q <= mmcm_rst_d;
            rst_q      <= rst_d;
            busy_q     <= busy_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef CORESCORE_LOCK_MON_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lk_prev_q <= 1'b0;
        end else begin
            lk_prev_q <= lk_q;
        end
    end
`endif

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_daddr    = daddr_q;
    assign o_di       = di_q;
    assign o_den      = den_q;
    assign o_dwe      = dwe_q;
    assign o_mmcm_rst = mmcm_rst_q;
    assign o_rst      = rst_q;

endmodule

// File: tb/tb_corescore_mmcm_drp_ctrl.sv
// Self-checking bench for corescore_mmcm_drp_ctrl: DRP responder with a
// scoreboard of expected accesses, an MMCM lock model, a table of divider
// vectors and hand-written sequences for timeout, reset and lock loss.

module tb_corescore_mmcm_drp_ctrl;

    localparam int unsigned RST_HOLD     = 16;
    localparam int unsigned LOCK_TIMEOUT = 200;
    localparam logic [6:0]  REG1         = 7'h08;
    localparam logic [6:0]  REG2         = 7'h09;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req;
    logic [7:0]  i_div;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [6:0]  o_daddr;
    logic [15:0] o_di;
    logic [15:0] i_do;
    logic        o_den;
    logic        o_dwe;
    logic        i_drdy;
    logic        o_mmcm_rst;
    logic        i_locked;
    logic        o_rst;

    corescore_mmcm_drp_ctrl #(
        .RST_HOLD     (RST_HOLD),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .REG1_ADDR    (REG1),
        .REG2_ADDR    (REG2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_div      (i_div),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_daddr    (o_daddr),
        .o_di       (o_di),
        .i_do       (i_do),
        .o_den      (o_den),
        .o_dwe      (o_dwe),
        .i_drdy     (i_drdy),
        .o_mmcm_rst (o_mmcm_rst),
        .i_locked   (i_locked),
        .o_rst      (o_rst)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // ---------------- DRP responder + scoreboard ----------------
    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t        sb_q[$];
    acc_t        mon_e;
    logic [15:0] rd1 = '0;
    logic [15:0] rd2 = '0;
    int          drp_delay = 1;
    bit          drp_mute  = 1'b0;
    int          den_count = 0;
    int          resp_cnt  = 0;
    logic [15:0] resp_data = '0;

    initial begin
        i_drdy = 1'b0;
        i_do   = '0;
        forever begin
            @(negedge i_clk);
            i_drdy = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    i_drdy = 1'b1;
                    i_do   = resp_data;
                end
            end
            if (!o_den && o_dwe) check("dwe_without_den", 32'(o_dwe), 32'd0);
            if (o_den) begin
                den_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_drp_access: addr 0x%0h we %0b, no access expected",
                             o_daddr, o_dwe);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("drp_we", 32'(o_dwe), 32'(mon_e.we));
                    check("drp_addr", 32'(o_daddr), 32'(mon_e.addr));
                    if (mon_e.we) check("drp_wdata", 32'(o_di), 32'(mon_e.data));
                    check("mmcm_rst_during_drp", 32'(o_mmcm_rst), 32'd1);
                end
                if (!drp_mute) begin
                    resp_cnt  = drp_delay;
                    resp_data = (o_daddr == REG1) ? rd1 : rd2;
                end
            end
        end
    end

    // ---------------- MMCM lock model ----------------
    int lock_dly        = 34;
    bit lock_force_low  = 1'b0;
    int lock_ctr        = 0;

    initial begin
        i_locked = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (lock_force_low || o_mmcm_rst) begin
                i_locked = 1'b0;
                lock_ctr = lock_dly;
            end else if (lock_ctr > 0) begin
                lock_ctr--;
            end else begin
                i_locked = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_rmw(input logic [15:0] w1, input logic [15:0] w2);
        sb_q.push_back('{we: 1'b0, addr: REG1, data: 16'h0000});
        sb_q.push_back('{we: 1'b1, addr: REG1, data: w1});
        sb_q.push_back('{we: 1'b0, addr: REG2, data: 16'h0000});
        sb_q.push_back('{we: 1'b1, addr: REG2, data: w2});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!o_done && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(o_done), 32'd1);
        check({tag, "_rst_low_at_done"}, 32'(o_rst), 32'd0);
        @(negedge i_clk);
        check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
    endtask

    task automatic count_mmcm_high(output int n);
        n = 0;
        while (o_mmcm_rst && n < 100) begin
            n++;
            @(negedge i_clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"},
              32'({o_mmcm_rst, o_rst, o_busy, o_den, o_dwe, o_done, o_err}),
              32'(7'b1110000));
        check({tag, "_daddr"}, 32'(o_daddr), 32'd0);
        check({tag, "_di"}, 32'(o_di), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  div;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] w1;
        logic [15:0] w2;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        int base;
        bit ok;

        vecs[0] = '{8'd50,  16'hF000, 16'hF3FF, 16'hF659, 16'hF3FF};
        vecs[1] = '{8'd7,   16'h0000, 16'h0000, 16'h00C4, 16'h0800};
        vecs[2] = '{8'd1,   16'h0000, 16'h0000, 16'h0001, 16'h0C00};
        vecs[3] = '{8'd2,   16'h0FFF, 16'h0FFF, 16'h0041, 16'h03FF};
        vecs[4] = '{8'd0,   16'hABCD, 16'h1234, 16'hA001, 16'h1E34};
        vecs[5] = '{8'd64,  16'h0000, 16'hFFFF, 16'h0FFF, 16'hF3FF};
        vecs[6] = '{8'd255, 16'h5000, 16'h0000, 16'h5FFF, 16'h0800};
        vecs[7] = '{8'd63,  16'h0000, 16'hC000, 16'h07E0, 16'hC800};
        vecs[8] = '{8'd3,   16'h0000, 16'h0400, 16'h0042, 16'h0800};

        i_rst_n = 1'b0;
        i_req   = 1'b0;
        i_div   = '0;
        repeat (4) @(negedge i_clk);
        check_reset_outputs("reset");

        // Power-up: MMCM reset width, then lock -> done latency.
        i_rst_n = 1'b1;
        count_mmcm_high(n);
        check("powerup_mmcm_rst_cycles", 32'(n), 32'(RST_HOLD));
        n = 0;
        while (!i_locked && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("powerup_locked_seen", 32'(i_locked), 32'd1);
        check("powerup_rst_before_lock", 32'(o_rst), 32'd1);
        lat = 0;
        while (!o_done && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        check("powerup_done_latency", 32'(lat), 32'd4);
        check("powerup_rst_falls_with_done", 32'(o_rst), 32'd0);
        check("powerup_idle", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check("powerup_done_pulse", 32'(o_done), 32'd0);

        // Divider table.
        lock_dly = 5;
        for (int v = 0; v < 9; v++) begin
            drp_delay = (v % 3) + 1;
            rd1 = vecs[v].rd1;
            rd2 = vecs[v].rd2;
            push_rmw(vecs[v].w1, vecs[v].w2);
            i_div = vecs[v].div;
            i_req = 1'b1;
            n = 0;
            while (n < 100) begin
                @(negedge i_clk);
                n++;
                if (n == 1) begin
                    i_div = 8'hA5;
                    if (v == 0) begin
                        check("req_busy", 32'(o_busy), 32'd1);
                        check("req_rst", 32'(o_rst), 32'd1);
                    end
                end
                if (n == 4) i_req = 1'b0;
                if (!o_mmcm_rst) break;
            end
            if (v == 0) check("min_path_mmcm_release", 32'(n), 32'd10);
            wait_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d_all_accesses", v), 32'(sb_q.size()), 32'd0);
            check($sformatf("vec%0d_no_err", v), 32'(o_err), 32'd0);
        end

        // DRDY never arrives.
        drp_mute = 1'b1;
        sb_q.push_back('{we: 1'b0, addr: REG1, data: 16'h0000});
        i_div = 8'd10;
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        n = 1;
        while (!o_err && n < int'(LOCK_TIMEOUT) + 50) begin
            @(negedge i_clk);
            n++;
        end
        check("drdy_timeout_err", 32'(o_err), 32'd1);
        ok = (n >= int'(LOCK_TIMEOUT)) && (n <= int'(LOCK_TIMEOUT) + 4);
        check("drdy_timeout_latency_window", 32'(ok), 32'd1);
        check("drdy_timeout_mmcm_released", 32'(o_mmcm_rst), 32'd0);
        wait_done("timeout");
        check("err_sticky", 32'(o_err), 32'd1);
        drp_mute = 1'b0;
        sb_q.delete();
        rd1 = vecs[0].rd1;
        rd2 = vecs[0].rd2;
        push_rmw(vecs[0].w1, vecs[0].w2);
        i_div = vecs[0].div;
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        check("err_cleared_by_req", 32'(o_err), 32'd0);
        wait_done("after_timeout");
        check("after_timeout_accesses", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of the write wait; late DRDY must be ignored.
        drp_delay = 10;
        push_rmw(vecs[1].w1, vecs[1].w2);
        rd1 = vecs[1].rd1;
        rd2 = vecs[1].rd2;
        base = den_count;
        i_div = vecs[1].div;
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        n = 0;
        while (den_count < base + 2 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("midreset_write_issued", 32'(den_count - base), 32'd2);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge i_clk);
        check_reset_outputs("midreset");
        base = den_count;
        i_rst_n = 1'b1;
        count_mmcm_high(n);
        check("midreset_prst_restart", 32'(n), 32'(RST_HOLD));
        wait_done("midreset");
        check("midreset_no_drp", 32'(den_count - base), 32'd0);
        check("midreset_no_err", 32'(o_err), 32'd0);
        drp_delay = 1;

        // Loss of lock while idle.
        base = den_count;
        repeat (3) @(negedge i_clk);
        lock_force_low = 1'b1;
        n = 0;
        while (i_locked && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        n = 0;
        while (!o_rst && n < 10) begin
            @(negedge i_clk);
            n++;
        end
`ifdef CORESCORE_LOCK_MON_EN
        check("lockmon_rst_within_3", 32'(o_rst && n <= 3), 32'd1);
        check("lockmon_no_mmcm_rst", 32'(o_mmcm_rst), 32'd0);
        lock_force_low = 1'b0;
        wait_done("lockmon");
`else
        check("nolockmon_rst_stays_low", 32'(o_rst), 32'd0);
        check("nolockmon_idle", 32'(o_busy), 32'd0);
        lock_force_low = 1'b0;
        repeat (10) @(negedge i_clk);
`endif
        check("lockloss_no_drp", 32'(den_count - base), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
